// File: rtl/legv8_pkg.sv
// Shared LEGv8 subset definitions: opcode values, instruction field positions and the ALU.
// The optional CBNZ opcode is enabled by defining LEGV8_CBNZ_EN.
package legv8_pkg;

    localparam int XLEN = 64;

    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_SUB  = 11'h658;
    localparam logic [10:0] OP_AND  = 11'h450;
    localparam logic [10:0] OP_ORR  = 11'h550;
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [9:0]  OP_ADDI = 10'h244;
    localparam logic [9:0]  OP_SUBI = 10'h344;
    localparam logic [7:0]  OP_CBZ  = 8'hB4;
    localparam logic [7:0]  OP_CBNZ = 8'hB5;
    localparam logic [5:0]  OP_B    = 6'h05;

    localparam int RD_LSB    = 0;
    localparam int RN_LSB    = 5;
    localparam int RM_LSB    = 16;
    localparam int IMM12_LSB = 10;
    localparam int ADDR9_LSB = 12;
    localparam int IMM19_LSB = 5;
    localparam int IMM26_LSB = 0;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_ORR,
        ALU_PASSB
    } alu_op_e;

    function automatic logic [XLEN-1:0] alu_eval(input alu_op_e op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [XLEN-1:0] r;
        case (op)
            ALU_ADD:   r = a + b;
            ALU_SUB:   r = a - b;
            ALU_AND:   r = a & b;
            ALU_ORR:   r = a | b;
            ALU_PASSB: r = b;
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/legv8_single_cycle_cpu_dmem.sv
// Data memory: doubleword array with combinational read and clocked write.
// Byte address; the low 3 bits are ignored and the index wraps modulo DEPTH.
module legv8_dmem
    import legv8_pkg::*;
#(
    parameter int    DEPTH     = 32,
    parameter string INIT_FILE = ""
) (
    input  logic            clk,
    input  logic            we,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [AW-1:0]   idx;

    assign idx   = AW'((addr >> 3) % 64'(DEPTH));
    assign rdata = mem_q[idx];

    // Power-up image only; reset deliberately leaves memory contents alone.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] = '0;
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[idx] <= wdata;
    end

endmodule

// File: rtl/legv8_single_cycle_cpu.sv
// Single-cycle LEGv8 subset CPU: ROM fetch, register file, decode, ALU, next-pc and data memory.
// Define LEGV8_CBNZ_EN to decode CBNZ (0xB5); otherwise that opcode executes as a NOP.
module legv8_single_cycle_cpu
    import legv8_pkg::*;
#(
    parameter int    IMEM_DEPTH = 64,
    parameter int    DMEM_DEPTH = 32,
    parameter string IMEM_FILE  = "imem.mem",
    parameter string DMEM_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [10:0] tempInstruction,
    output logic [63:0] ALU_result,
    output logic [63:0] data_mem_out,
    output logic [63:0] pc
);

    localparam int IW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

    logic [31:0] rom [IMEM_DEPTH];

    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) rom[i] = '0;
    end

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] regs_q [31];
    logic [XLEN-1:0] regs_d [31];

    logic [IW-1:0]   rom_idx;
    logic [31:0]     instr;
    logic [4:0]      rd_a, rn_a, rm_a;
    logic [XLEN-1:0] rn_val, rm_val, rt_val;
    logic [XLEN-1:0] alu_a, alu_b, br_off, wb_data;
    alu_op_e         alu_op;
    logic            reg_we, mem_we, mem_to_reg, br_taken;

    assign rom_idx = IW'((pc_q >> 2) % 64'(IMEM_DEPTH));
    assign instr   = rom[rom_idx];
    assign rd_a    = instr[RD_LSB +: 5];
    assign rn_a    = instr[RN_LSB +: 5];
    assign rm_a    = instr[RM_LSB +: 5];

    // X31 is the zero register; the array only holds X0..X30.
    assign rn_val = (rn_a == 5'd31) ? '0 : regs_q[rn_a];
    assign rm_val = (rm_a == 5'd31) ? '0 : regs_q[rm_a];
    assign rt_val = (rd_a == 5'd31) ? '0 : regs_q[rd_a];

    always_comb begin
        alu_op     = ALU_ADD;
        alu_a      = '0;
        alu_b      = '0;
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        mem_to_reg = 1'b0;
        br_taken   = 1'b0;
        br_off     = '0;
        case (instr[31:21])
            OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                alu_a  = rn_val;
                alu_b  = rm_val;
                reg_we = 1'b1;
                case (instr[31:21])
                    OP_SUB:  alu_op = ALU_SUB;
                    OP_AND:  alu_op = ALU_AND;
                    OP_ORR:  alu_op = ALU_ORR;
                    default: alu_op = ALU_ADD;
                endcase
            end
            OP_LDUR, OP_STUR: begin
                alu_a = rn_val;
                alu_b = {{(XLEN-9){instr[ADDR9_LSB+8]}}, instr[ADDR9_LSB +: 9]};
                if (instr[31:21] == OP_LDUR) begin
                    reg_we     = 1'b1;
                    mem_to_reg = 1'b1;
                end else begin
                    mem_we = 1'b1;
                end
            end
            default: begin
                // Shorter opcodes are matched only after every 11-bit opcode missed.
                if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI) begin
                    alu_op = (instr[31:22] == OP_SUBI) ? ALU_SUB : ALU_ADD;
                    alu_a  = rn_val;
                    alu_b  = {{(XLEN-12){1'b0}}, instr[IMM12_LSB +: 12]};
                    reg_we = 1'b1;
                end else if (instr[31:24] == OP_CBZ) begin
                    alu_op   = ALU_PASSB;
                    alu_b    = rt_val;
                    br_taken = (rt_val == '0);
                    br_off   = {{(XLEN-19){instr[IMM19_LSB+18]}}, instr[IMM19_LSB +: 19]};
                end
`ifdef LEGV8_CBNZ_EN
                else if (instr[31:24] == OP_CBNZ) begin
                    alu_op   = ALU_PASSB;
                    alu_b    = rt_val;
                    br_taken = (rt_val != '0);
                    br_off   = {{(XLEN-19){instr[IMM19_LSB+18]}}, instr[IMM19_LSB +: 19]};
                end
`endif
                else if (instr[31:26] == OP_B) begin
                    br_taken = 1'b1;
                    br_off   = {{(XLEN-26){instr[IMM26_LSB+25]}}, instr[IMM26_LSB +: 26]};
                end
            end
        endcase
    end

    assign ALU_result = alu_eval(alu_op, alu_a, alu_b);
    assign wb_data    = mem_to_reg ? data_mem_out : ALU_result;

    always_comb begin
        regs_d = regs_q;
        if (reg_we && rd_a != 5'd31) regs_d[rd_a] = wb_data;
        pc_d = br_taken ? pc_q + (br_off << 2) : pc_q + 64'd4;
    end

    // Stores are blocked while reset is held so the frozen fetch of word 0 cannot write memory.
    legv8_dmem #(
        .DEPTH     (DMEM_DEPTH),
        .INIT_FILE (DMEM_FILE)
    ) u_dmem (
        .clk   (clk),
        .we    (mem_we & rst_n),
        .addr  (ALU_result),
        .wdata (rt_val),
        .rdata (data_mem_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
            for (int i = 0; i < 31; i++) regs_q[i] <= '0;
        end else begin
            pc_q   <= pc_d;
            regs_q <= regs_d;
        end
    end

    assign tempInstruction = instr[31:21];
    assign pc              = pc_q;

endmodule

// File: tb/tb_legv8_single_cycle_cpu.sv
// Bench for legv8_single_cycle_cpu: a directed prologue plus random instructions, run through an
// instruction-level reference model whose per-cycle expectations are queued and checked by a monitor.
module tb_legv8_single_cycle_cpu;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] tempInstruction;
    logic [63:0] ALU_result;
    logic [63:0] data_mem_out;
    logic [63:0] pc;

    legv8_single_cycle_cpu #(
        .IMEM_DEPTH (64),
        .DMEM_DEPTH (32),
        .IMEM_FILE  (""),
        .DMEM_FILE  ("")
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tempInstruction (tempInstruction),
        .ALU_result      (ALU_result),
        .data_mem_out    (data_mem_out),
        .pc              (pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [10:0] op;
        logic [63:0] alu;
        logic [63:0] dout;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] prog  [64];
    logic [63:0] m_x   [32];
    logic [63:0] m_mem [32];
    logic [63:0] m_pc;
    int          n_pass  = 0;
    int          n_total = 0;

    localparam int K1 = 600;
    localparam int K2 = 300;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm,
                                          input logic [4:0] rn, input logic [4:0] rd);
        return {op, rm, 6'd0, rn, rd};
    endfunction
    function automatic logic [31:0] enc_i(input logic [9:0] op, input logic [11:0] imm,
                                          input logic [4:0] rn, input logic [4:0] rd);
        return {op, imm, rn, rd};
    endfunction
    function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] a9,
                                          input logic [4:0] rn, input logic [4:0] rt);
        return {op, a9, 2'b00, rn, rt};
    endfunction
    function automatic logic [31:0] enc_cb(input logic [7:0] op, input logic [18:0] imm,
                                           input logic [4:0] rt);
        return {op, imm, rt};
    endfunction
    function automatic logic [31:0] enc_b(input logic [25:0] imm);
        return {6'h05, imm};
    endfunction

    function automatic logic [31:0] rand_instr();
        int          sel;
        int          off;
        logic [31:0] w;
        logic [4:0]  r1, r2, r3;
        sel = $urandom_range(0, 13);
        r1  = 5'($urandom_range(0, 31));
        r2  = 5'($urandom_range(0, 31));
        r3  = 5'($urandom_range(0, 31));
        off = $urandom_range(0, 12) - 6;
        if (off == 0) off = 2;
        case (sel)
            0, 1:    w = enc_r(11'h458, r1, r2, r3);
            2:       w = enc_r(11'h658, r1, r2, r3);
            3:       w = enc_r(11'h450, r1, r2, r3);
            4:       w = enc_r(11'h550, r1, r2, r3);
            5:       w = enc_i(10'h244, 12'($urandom), r2, r3);
            6:       w = enc_i(10'h344, 12'($urandom), r2, r3);
            7:       w = enc_d(11'h7C2, 9'($urandom), ($urandom_range(0, 1) != 0) ? 5'd31 : r2, r3);
            8:       w = enc_d(11'h7C0, 9'($urandom), ($urandom_range(0, 1) != 0) ? 5'd31 : r2, r3);
            9:       w = enc_cb(8'hB4, 19'(off), r3);
            10:      w = enc_cb(8'hB5, 19'(off), r3);
            11:      w = enc_b(26'(off));
            12:      w = 32'h0;
            default: w = $urandom;
        endcase
        return w;
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [63:0] xr(input logic [4:0] r);
        return (r == 5'd31) ? 64'd0 : m_x[r];
    endfunction

    // Two's-complement sign extension of a bits-wide field held zero-extended in v.
    function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
        logic [63:0] m;
        m = 64'd1 << (bits - 1);
        return (v ^ m) - m;
    endfunction

    task automatic model_step(output exp_t e);
        logic [31:0] w;
        logic [10:0] op11;
        logic [4:0]  rd, rn, rm;
        logic [63:0] res, npc, wb;
        bit          wr_reg, wr_mem, is_load;
        w       = prog[int'((m_pc >> 2) % 64)];
        op11    = w[31:21];
        rd      = w[4:0];
        rn      = w[9:5];
        rm      = w[20:16];
        res     = 64'd0;
        npc     = m_pc + 64'd4;
        wr_reg  = 0;
        wr_mem  = 0;
        is_load = 0;
        if (op11 == 11'h458) begin
            res = xr(rn) + xr(rm); wr_reg = 1;
        end else if (op11 == 11'h658) begin
            res = xr(rn) - xr(rm); wr_reg = 1;
        end else if (op11 == 11'h450) begin
            res = xr(rn) & xr(rm); wr_reg = 1;
        end else if (op11 == 11'h550) begin
            res = xr(rn) | xr(rm); wr_reg = 1;
        end else if (op11 == 11'h7C2) begin
            res = xr(rn) + sx(64'(w[20:12]), 9); is_load = 1;
        end else if (op11 == 11'h7C0) begin
            res = xr(rn) + sx(64'(w[20:12]), 9); wr_mem = 1;
        end else if (w[31:22] == 10'h244) begin
            res = xr(rn) + 64'(w[21:10]); wr_reg = 1;
        end else if (w[31:22] == 10'h344) begin
            res = xr(rn) - 64'(w[21:10]); wr_reg = 1;
        end else if (w[31:24] == 8'hB4) begin
            res = xr(rd);
            if (res == 64'd0) npc = m_pc + sx(64'(w[23:5]), 19) * 4;
        end
`ifdef LEGV8_CBNZ_EN
        else if (w[31:24] == 8'hB5) begin
            res = xr(rd);
            if (res != 64'd0) npc = m_pc + sx(64'(w[23:5]), 19) * 4;
        end
`endif
        else if (w[31:26] == 6'h05) begin
            npc = m_pc + sx(64'(w[25:0]), 26) * 4;
        end
        e.pc   = m_pc;
        e.op   = op11;
        e.alu  = res;
        e.dout = m_mem[int'((res >> 3) % 32)];
        wb     = is_load ? e.dout : res;
        if (wr_mem) m_mem[int'((res >> 3) % 32)] = xr(rd);
        if ((wr_reg || is_load) && rd != 5'd31) m_x[rd] = wb;
        m_pc = npc;
    endtask

    task automatic model_reset();
        m_pc = 64'd0;
        for (int i = 0; i < 32; i++) m_x[i] = 64'd0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc", pc, e.pc);
                check("opcode", 64'(tempInstruction), 64'(e.op));
                check("alu_result", ALU_result, e.alu);
                check("data_mem_out", data_mem_out, e.dout);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        exp_t e;
        #1;
        for (int i = 0; i < 64; i++) prog[i] = 32'h0;
        prog[0]  = enc_i(10'h244, 12'd5, 5'd31, 5'd1);     // ADDI X1,XZR,#5
        prog[1]  = enc_i(10'h244, 12'd7, 5'd31, 5'd2);     // ADDI X2,XZR,#7
        prog[2]  = enc_r(11'h458, 5'd2, 5'd1, 5'd3);       // ADD  X3,X1,X2
        prog[3]  = enc_r(11'h658, 5'd2, 5'd1, 5'd4);       // SUB  X4,X1,X2
        prog[4]  = enc_d(11'h7C0, 9'd16, 5'd31, 5'd3);     // STUR X3,[XZR,#16]
        prog[5]  = enc_d(11'h7C2, 9'd16, 5'd31, 5'd5);     // LDUR X5,[XZR,#16]
        prog[6]  = enc_r(11'h458, 5'd31, 5'd5, 5'd6);      // ADD  X6,X5,XZR
        prog[7]  = enc_r(11'h458, 5'd2, 5'd1, 5'd31);      // ADD  XZR,X1,X2
        prog[8]  = enc_cb(8'hB4, 19'd3, 5'd31);            // 0x20 CBZ XZR,#+3
        prog[11] = enc_r(11'h458, 5'd31, 5'd31, 5'd7);     // 0x2C ADD X7,XZR,XZR
        prog[12] = enc_i(10'h244, 12'd1, 5'd31, 5'd13);    // ADDI X13,XZR,#1
        prog[13] = enc_cb(8'hB4, 19'd3, 5'd1);             // 0x34 CBZ X1,#+3 (not taken)
        prog[14] = enc_cb(8'hB4, 19'd4, 5'd13);            // 0x38 CBZ X13,#+4
        prog[15] = enc_i(10'h344, 12'd1, 5'd13, 5'd13);    // SUBI X13,X13,#1
        prog[16] = enc_b(26'h3FFFFFE);                     // 0x40 B #-2
        prog[17] = enc_r(11'h550, 5'd2, 5'd1, 5'd16);      // ORR X16,X1,X2 (skipped)
        prog[19] = enc_r(11'h450, 5'd2, 5'd1, 5'd17);      // 0x4C AND X17,X1,X2
        prog[20] = enc_cb(8'hB5, 19'd2, 5'd1);             // 0x50 CBNZ X1,#+2
        prog[21] = enc_i(10'h244, 12'd1, 5'd31, 5'd15);    // ADDI X15,XZR,#1
        for (int i = 22; i < 64; i++) prog[i] = rand_instr();
        for (int i = 0; i < 64; i++) dut.rom[i] = prog[i];
        for (int i = 0; i < 32; i++) m_mem[i] = 64'd0;
        model_reset();

        // Reset held: pc pinned at 0 and outputs reflect word 0.
        repeat (2) begin
            @(negedge clk);
            check("rst_pc", pc, 64'd0);
            check("rst_opcode", 64'(tempInstruction), 64'(prog[0][31:21]));
            check("rst_alu", ALU_result, 64'd5);
        end

        for (int i = 0; i < K1; i++) begin
            model_step(e);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (K1) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("phase1_drained", 64'(exp_q.size()), 64'd0);
        check("midrst_pc", pc, 64'd0);
        check("midrst_opcode", 64'(tempInstruction), 64'(prog[0][31:21]));

        // Registers restart from zero; data memory keeps what phase 1 left.
        model_reset();
        for (int i = 0; i < K2; i++) begin
            model_step(e);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (K2) @(posedge clk);
        #1;
        check("phase2_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
